// File: rtl/wb_init_bridge.sv
// ---------------------------------------------------------------------------
// wb_init_bridge
//
// Purpose:
//   Turns a simple valid/ready command stream into single Wishbone classic
//   bus cycles. Only one transaction is in flight at a time. Each accepted
//   command produces exactly one response: the read data on an ack, or an
//   error flag if the responder stays silent for TIMEOUT bus cycles.
//
// Parameters:
//   TIMEOUT    - bus cycles to wait for ack before aborting (1..65535)
//
// Ports:
//   clk, rst   - single clock; asynchronous active-high reset
//   cmd_*      - command channel (valid/ready, we, adr, dat, sel)
//   rsp_*      - response channel (valid/ready, dat, err)
//   wbm_*_o    - Wishbone initiator outputs (cyc, stb, we, adr, dat, sel)
//   wbm_*_i    - Wishbone responder inputs (dat, ack)
// ---------------------------------------------------------------------------
module wb_init_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    logic [15:0] wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt_q + 16'd1;

    // State register and all datapath flops. Because cyc/stb and rsp_valid
    // are decoded from the state, reset kills an in-flight bus cycle
    // immediately without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 16'd0;
            we_q       <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            rsp_dat_q  <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state logic. Everything holds by default, which is what keeps the
    // bus signals stable during BUS and the response stable during RESP.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d       = cmd_we;
                    adr_d      = cmd_adr;
                    dat_d      = cmd_dat;
                    sel_d      = cmd_sel;
                    wait_cnt_d = 16'd0;
                    state_d    = BUS;
                end
            end

            BUS: begin
                // Ack is tested first so that an ack landing on the very
                // cycle the wait count reaches TIMEOUT still completes.
                if (wbm_ack_i) begin
                    rsp_err_d = 1'b0;
                    rsp_dat_d = we_q ? 32'd0 : wbm_dat_i;
                    state_d   = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == TIMEOUT_CNT) begin
                        rsp_err_d = 1'b1;
                        rsp_dat_d = 32'd0;
                        state_d   = RESP;
                    end
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

    assign wbm_cyc_o = (state_q == BUS);
    assign wbm_stb_o = (state_q == BUS);
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_init_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_init_bridge
//
// Purpose:
//   Self-checking bench for wb_init_bridge (TIMEOUT = 4). Each command is
//   issued together with the responder behaviour it will meet (ack delay,
//   read data). The reference model turns that into an expected bus cycle
//   and an expected response, which are queued; independent monitors pop
//   and compare them against what the DUT presents on the bus and on the
//   response channel.
// ---------------------------------------------------------------------------
module tb_wb_init_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        wbm_ack_i;

    logic        bus_ack   = 1'b0;
    logic        stray_ack = 1'b0;

    assign wbm_ack_i = bus_ack | stray_ack;

    int checks = 0;
    int errors = 0;

    // Response-channel policy: rand_ready randomises rsp_ready; the monitor
    // forces it low until bp_done catches up with bp_target.
    bit rand_ready = 1'b0;
    int bp_target  = 0;
    int bp_done    = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;   // BUS cycle on which the responder acks, 0 = never
        int          len;     // expected number of cycles cyc stays high
        logic [31:0] rdata;
    } bus_txn_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_txn_t;

    bus_txn_t bus_q[$];
    rsp_txn_t rsp_q[$];

    wb_init_bridge #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Offers one command, waits (bounded) for acceptance and queues what the
    // reference model predicts for it. Outcome rule: an ack within the first
    // TO bus cycles completes the access (reads return the responder data,
    // writes return 0); otherwise the access times out after exactly TO
    // cycles with err=1 and data 0.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input int delay, input logic [31:0] rdata,
                                 input bit expect_rsp, output int waited);
        bus_txn_t b;
        rsp_txn_t r;
        bit       timed_out;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        while (!cmd_ready && waited < 300) begin
            if (rsp_valid) checkOutput("cyc_low_while_rsp", {31'd0, wbm_cyc_o}, 32'd0);
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_wait_expired", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        timed_out = (delay < 1) || (delay > TO);
        b.we    = we;
        b.adr   = adr;
        b.dat   = dat;
        b.sel   = sel;
        b.delay = timed_out ? 0 : delay;
        b.len   = timed_out ? TO : delay;
        b.rdata = rdata;
        bus_q.push_back(b);
        if (expect_rsp) begin
            r.err = timed_out;
            r.dat = (timed_out || we) ? 32'd0 : rdata;
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
    endtask

    // Bounded wait for every queued expectation to be consumed.
    task automatic waitDrain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || !cmd_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_in_time", {31'd0, n < 500}, 32'd1);
    endtask

    // Responder and bus monitor: pops the expected cycle when cyc rises,
    // checks the bus fields every BUS cycle, acks on the programmed cycle and
    // checks the cycle length when cyc falls.
    bus_txn_t cur;
    int       bus_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            bus_cnt = 0;
            bus_ack = 1'b0;
        end else if (wbm_cyc_o) begin
            if (bus_cnt == 0) begin
                if (bus_q.size() == 0) begin
                    checkOutput("unexpected_bus_cycle", 32'd1, 32'd0);
                    cur.we = 1'b0; cur.adr = 32'd0; cur.dat = 32'd0; cur.sel = 4'd0;
                    cur.delay = 1; cur.len = 1; cur.rdata = 32'd0;
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            checkOutput("bus_stb", {31'd0, wbm_stb_o}, 32'd1);
            checkOutput("bus_we",  {31'd0, wbm_we_o}, {31'd0, cur.we});
            checkOutput("bus_adr", wbm_adr_o, cur.adr);
            checkOutput("bus_dat", wbm_dat_o, cur.dat);
            checkOutput("bus_sel", {28'd0, wbm_sel_o}, {28'd0, cur.sel});
            bus_cnt++;
            bus_ack   = (bus_cnt == cur.delay);
            wbm_dat_i = cur.we ? $urandom : cur.rdata;
        end else begin
            if (bus_cnt != 0) begin
                checkOutput("bus_len", 32'(bus_cnt), 32'(cur.len));
                bus_cnt = 0;
            end
            checkOutput("stb_low_outside_bus", {31'd0, wbm_stb_o}, 32'd0);
            bus_ack   = 1'b0;
            wbm_dat_i = $urandom;
        end
    end

    // Response monitor: picks rsp_ready for the coming edge, then compares
    // the presented response against the head of the queue on every RESP
    // cycle (which also proves it is held stable), popping on handshake.
    rsp_txn_t exp_rsp;

    always @(negedge clk) begin
        if (!rst) begin
            if (bp_done < bp_target) begin
                rsp_ready = 1'b0;
                if (rsp_valid) bp_done++;
            end else if (rand_ready) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rsp_ready = 1'b1;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_rsp = rsp_q[0];
                    checkOutput("rsp_dat", rsp_dat, exp_rsp.dat);
                    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_rsp.err});
                    checkOutput("cmd_ready_low_in_rsp", {31'd0, cmd_ready}, 32'd0);
                    if (rsp_ready) void'(rsp_q.pop_front());
                end
            end
        end
    end

    // Hard stop in case something upstream hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int waited;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'd0;
        cmd_dat   = 32'd0;
        cmd_sel   = 4'd0;

        // Reset values, then release between edges.
        repeat (3) @(negedge clk);
        checkOutput("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput("rst_we",  {31'd0, wbm_we_o}, 32'd0);
        checkOutput("rst_adr", wbm_adr_o, 32'd0);
        checkOutput("rst_dat", wbm_dat_o, 32'd0);
        checkOutput("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_dat", rsp_dat, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] directed: write, read, timeout, coincident ack");
        applyStimulus(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 1'b1, waited);
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b1, waited);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'hAAAA_5555, 1'b1, waited);
        applyStimulus(1'b1, 32'h3000_000C, 32'h0BAD_F00D, 4'hC, 1, 32'h0, 1'b1, waited);
        applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, TO, 32'hCAFE_0001, 1'b1, waited);
        applyStimulus(1'b1, 32'h3000_0014, 32'h1111_2222, 4'h1, TO + 1, 32'h0, 1'b1, waited);
        waitDrain();

        $display("[TB] directed: stray ack while idle");
        @(negedge clk);
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stray_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            checkOutput("stray_cyc", {31'd0, wbm_cyc_o}, 32'd0);
            checkOutput("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        stray_ack = 1'b0;

        $display("[TB] directed: response backpressure");
        bp_target = bp_done + 10;
        applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'h5A5A_A5A5, 1'b1, waited);
        applyStimulus(1'b1, 32'h3000_0024, 32'h7777_8888, 4'hF, 2, 32'h0, 1'b1, waited);
        checkOutput("bp_held_cmd", {31'd0, waited >= 10}, 32'd1);
        waitDrain();

        $display("[TB] directed: reset during bus cycle");
        applyStimulus(1'b1, 32'h3000_0030, 32'h1357_9BDF, 4'hF, 0, 32'h0, 1'b0, waited);
        @(posedge clk);
        #2;
        checkOutput("cyc_before_rst", {31'd0, wbm_cyc_o}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput("rst_async_stb", {31'd0, wbm_stb_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("post_rst_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        applyStimulus(1'b0, 32'h3000_0034, 32'h0, 4'hF, 3, 32'h2468_ACE0, 1'b1, waited);
        waitDrain();

        $display("[TB] randomized traffic");
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                          4'($urandom_range(1, 15)), $urandom_range(0, TO + 1),
                          $urandom, 1'b1, waited);
        end
        waitDrain();

        checkOutput("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        checkOutput("bus_queue_empty", 32'(bus_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
